// File: rtl/reg_wb_ctrl.sv
// rtl/reg_wb_ctrl.sv - register-file writeback arbiter with load-return FIFO and load scoreboard
module reg_wb_ctrl #(
    parameter int LDQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [1:0]  alu_thread,
    input  logic [3:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [1:0]  ld_thread,
    input  logic [3:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        iss_valid,
    input  logic [1:0]  iss_thread,
    input  logic [3:0]  iss_rd,
    input  logic [1:0]  q_thread,
    input  logic [3:0]  q_rs,
    input  logic [3:0]  q_rt,
    output logic        q_stall,
    output logic        wena,
    output logic [1:0]  w_thread,
    output logic [3:0]  waddr,
    output logic [31:0] wdata,
    output logic [2:0]  ldq_count,
    output logic        err_sticky
);
    localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Entry layout: {thread[37:36], rd[35:32], data[31:0]}
    logic [37:0]   ldq_mem [LDQ_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [63:0]   pending;

    logic          full;
    logic          empty;
    logic [37:0]   head;
    logic          alu_acc;
    logic          ld_acc;
    logic          pop;
    logic          win_valid;
    logic [1:0]    win_thread;
    logic [3:0]    win_rd;
    logic [31:0]   win_data;
    logic          set_en;
    logic          err_set;
    logic [63:0]   pending_next;

    always_comb begin
        full       = (count == CW'(LDQ_DEPTH));
        empty      = (count == '0);
        head       = ldq_mem[rd_ptr];
        ld_ready   = !full;
        alu_ready  = !full;
        alu_acc    = alu_valid && !full;
        ld_acc     = ld_valid && !full;
        // Head is popped when full, or when no ALU result competes for the port.
        pop        = full || (!alu_valid && !empty);
        win_valid  = alu_acc || pop;
        win_thread = alu_acc ? alu_thread : head[37:36];
        win_rd     = alu_acc ? alu_rd     : head[35:32];
        win_data   = alu_acc ? alu_data   : head[31:0];
        set_en     = iss_valid && (iss_rd != 4'd0);
        err_set    = (set_en && pending[{iss_thread, iss_rd}])
                  || (alu_acc && pending[{alu_thread, alu_rd}]);
        pending_next = pending;
        if (pop)
            pending_next[{head[37:36], head[35:32]}] = 1'b0;
        // Set is applied after clear so it wins on a collision.
        if (set_en)
            pending_next[{iss_thread, iss_rd}] = 1'b1;
        q_stall    = ((q_rs != 4'd0) && pending[{q_thread, q_rs}])
                  || ((q_rt != 4'd0) && pending[{q_thread, q_rt}]);
        ldq_count  = 3'(count);
    end

    always_ff @(posedge clk) begin
        if (!reset && ld_acc)
            ldq_mem[wr_ptr] <= {ld_thread, ld_rd, ld_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            wena       <= 1'b0;
            w_thread   <= '0;
            waddr      <= '0;
            wdata      <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (ld_acc)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (ld_acc && !pop)
                count <= count + CW'(1);
            else if (!ld_acc && pop)
                count <= count - CW'(1);
            pending <= pending_next;
            wena    <= win_valid && (win_rd != 4'd0);
            if (win_valid) begin
                w_thread <= win_thread;
                waddr    <= win_rd;
                wdata    <= win_data;
            end
            if (err_set)
                err_sticky <= 1'b1;
        end
    end
endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter LDQ_DEPTH, default 4, load-return FIFO depth in entries (power of two, at least 2).
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alu_valid/alu_thread/alu_rd/alu_data  in  1/2/4/32  ALU result for writeback; alu_ready out 1 accepts it.
REQ-005 ld_valid/ld_thread/ld_rd/ld_data  in  1/2/4/32  memory load return; ld_ready out 1 accepts it.
REQ-006 iss_valid/iss_thread/iss_rd  in  1/2/4  load issue notice; marks {thread,rd} pending.
REQ-007 q_thread/q_rs/q_rt  in  2/4/4  hazard query for the decode stage.
REQ-008 q_stall  out  1  combinational; 1 when {q_thread,q_rs} or {q_thread,q_rt} is pending.
REQ-009 wena/w_thread/waddr/wdata  out  1/2/4/32  registered register-file write port.
REQ-010 ldq_count  out  3  current FIFO occupancy (0..LDQ_DEPTH).
REQ-011 err_sticky  out  1  sticky protocol-error flag.

Function
REQ-012 ALU handshake completes on alu_valid&alu_ready; load handshake completes on ld_valid&ld_ready.
REQ-013 ld_ready SHALL be 1 when ldq_count<LDQ_DEPTH; an accepted load enters the FIFO tail.
REQ-014 Arbitration each cycle, in this priority: (a) FIFO full: FIFO head wins, alu_ready=0; (b) alu_valid: ALU wins, alu_ready=1; (c) otherwise: FIFO head wins if non-empty.
REQ-015 alu_ready SHALL be 1 whenever the FIFO is not full, regardless of alu_valid.
REQ-016 The winner is registered into w_thread/waddr/wdata at the edge; wena is 1 the following cycle, for exactly 1 cycle per write; latency is 1 cycle.
REQ-017 A winner with rd==0 is consumed (FIFO pop/ALU accept) but SHALL produce wena=0.
REQ-018 With no winner, wena=0 and w_thread/waddr/wdata hold their previous values.
REQ-019 FIFO push and pop in the same cycle leave ldq_count unchanged; pointers wrap modulo LDQ_DEPTH.
REQ-020 A load arriving when the FIFO is empty and no ALU write is pending SHALL NOT bypass the FIFO; earliest wena is 2 cycles after acceptance.
REQ-021 Scoreboard: 64 pending bits indexed {thread,rd}; iss_valid with rd!=0 sets the bit; rd==0 is ignored.
REQ-022 A FIFO-head writeback clears the bit {thread,rd} at the same edge that it registers the write; ALU writebacks never clear bits.
REQ-023 Simultaneous set and clear of the same bit: set wins, bit = 1.
REQ-024 iss_valid targeting an already-pending bit SHALL set err_sticky; the bit stays 1.
REQ-025 An accepted ALU write to a pending {thread,rd} SHALL set err_sticky; the write still proceeds.
REQ-026 q_stall reflects the scoreboard after the last edge; same-cycle iss_valid or clears are not visible. Queries of rd 0 never stall.

Reset
REQ-027 While reset=1 at an edge, the following SHALL all clear: FIFO (ldq_count=0), all 64 pending bits, wena, w_thread, waddr, wdata, and err_sticky.
REQ-028 Handshakes presented during a reset cycle are dropped and produce no write.
REQ-029 Reset mid-operation discards queued loads; no wena occurs in the cycle after reset.
REQ-030 After reset: ld_ready=1, alu_ready=1, q_stall=0.

Verification
REQ-031 ALU write: alu_valid, thread 2, rd 5, 0xDEADBEEF -> next cycle wena=1, w_thread=2, waddr=5, wdata=0xDEADBEEF.
REQ-032 Issue and return: iss thread 1, rd 3; query thread 1, rs 3 -> q_stall=1. Load return of 0x1234 -> wena=1 two cycles after acceptance; q_stall=0 from that cycle.
REQ-033 FIFO full priority: continuous alu_valid with 4 loads queued -> alu_ready=0 and ld_ready=0. The head drains; ldq_count goes 4->3 and alu_ready returns to 1.
REQ-034 rd 0: ALU write to rd 0 -> wena=0. iss to rd 0 -> q_stall remains 0.
REQ-035 Errors: iss thread 0, rd 7 twice -> err_sticky=1. Separately, ALU write to pending thread 0, rd 7 -> err_sticky=1 and wena=1.
REQ-036 Reset mid-operation: 3 loads queued, reset for 1 cycle -> ldq_count=0, no wena afterwards, and all q_stall queries return 0.
